// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between the two requesters and the arbitrated 2:1 mux.
// The arbiter side uses the slave modport; requesters and consumers use master.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 1
);

  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output req_a,
    output req_b,
    output a,
    output b,
    input  gnt_a,
    input  gnt_b,
    input  sel,
    input  y,
    input  y_valid
  );

  modport slave (
    input  req_a,
    input  req_b,
    input  a,
    input  b,
    output gnt_a,
    output gnt_b,
    output sel,
    output y,
    output y_valid
  );

endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux.
// One-hot registered grants with a bounded hold under contention.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux2_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [3:0] CMAX = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     nstate;
  logic [3:0] cnt;
  logic       last;
  logic       sel_q;
  logic       enter;
  logic       hold_done;

  assign hold_done = (cnt == CMAX);
  assign enter     = (nstate != state) &&
                     (nstate != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Rotation only happens when the other side is waiting.
  always_comb begin
    nstate = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.req_a && bus.req_b) begin
          nstate = last ? GNT_A : GNT_B;
        end else if (bus.req_a) begin
          nstate = GNT_A;
        end else if (bus.req_b) begin
          nstate = GNT_B;
        end
      end
      (state == GNT_A): begin
        if (!bus.req_a) begin
          nstate = bus.req_b ? GNT_B : IDLE;
        end else if (bus.req_b && hold_done) begin
          nstate = GNT_B;
        end
      end
      (state == GNT_B): begin
        if (!bus.req_b) begin
          nstate = bus.req_a ? GNT_A : IDLE;
        end else if (bus.req_a && hold_done) begin
          nstate = GNT_A;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (enter) begin
      cnt <= 4'd0;
    end else if (state != IDLE && !hold_done) begin
      cnt <= cnt + 4'd1;
    end
  end

  // last=1 at reset so A wins the first contested round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (enter) begin
      last <= (nstate == GNT_B);
    end
  end

  // sel keeps its value through IDLE to avoid a glitch on y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
    end else if (nstate == GNT_A) begin
      sel_q <= 1'b0;
    end else if (nstate == GNT_B) begin
      sel_q <= 1'b1;
    end
  end

  always_comb begin
    bus.gnt_a   = (state == GNT_A);
    bus.gnt_b   = (state == GNT_B);
    bus.y_valid = (state == GNT_A) ||
                  (state == GNT_B);
    bus.sel     = sel_q;
    bus.y       = sel_q ? bus.b : bus.a;
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.gnt_a && bus.gnt_b)
  );

  a_sel_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.gnt_a |-> !bus.sel
  );

  a_sel_b: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.gnt_b |-> bus.sel
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: vector table plus scoreboard queue,
// with hand-written async-reset and MAX_HOLD=1 sequences.
module tb_mux2_rr_arbiter;

  typedef struct {
    logic ra, rb, a, b;
    logic ga, gb, sel, yv, y;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(1)) if4 ();
  mux2_rr_arbiter_if #(.WIDTH(1)) if1 ();

  mux2_rr_arbiter #(
    .WIDTH(1),
    .MAX_HOLD(4)
  ) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if4.slave)
  );

  mux2_rr_arbiter #(
    .WIDTH(1),
    .MAX_HOLD(1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if1.slave)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  function automatic logic [4:0] outs4();
    return {if4.gnt_a, if4.gnt_b, if4.sel,
            if4.y_valid, if4.y[0]};
  endfunction

  function automatic logic [4:0] outs1();
    return {if1.gnt_a, if1.gnt_b, if1.sel,
            if1.y_valid, if1.y[0]};
  endfunction

  task automatic add(
    input logic ra, rb, a, b,
    input logic ga, gb, sel, yv, y
  );
    vec_t v;
    v.ra = ra; v.rb = rb; v.a = a; v.b = b;
    v.ga = ga; v.gb = gb; v.sel = sel;
    v.yv = yv; v.y = y;
    tbl.push_back(v);
  endtask

  task automatic expect_out(
    input string name,
    input logic [4:0] e
  );
    sb_t s;
    s.name = name;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  // act/exp packed as {gnt_a,gnt_b,sel,y_valid,y}
  task automatic check(input logic [4:0] act);
    sb_t s;
    n_vec++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty got %b want <none>", act);
    end else begin
      s = sbq.pop_front();
      if (act !== s.exp) begin
        n_bad++;
        $display("FAIL %s got %b want %b",
                 s.name, act, s.exp);
      end
    end
  endtask

  task automatic drive4(input logic ra, rb, a, b);
    if4.req_a = ra;
    if4.req_b = rb;
    if4.a     = a;
    if4.b     = b;
  endtask

  initial begin
    // both requesting from reset: A x4, B x4, A x4, B x4
    for (int i = 0; i < 16; i++) begin
      if (((i / 4) % 2) == 0)
        add(1, 1, 1, 0, 1, 0, 0, 1, 1);
      else
        add(1, 1, 1, 0, 0, 1, 1, 1, 0);
    end
    add(1, 1, 0, 1, 1, 0, 0, 1, 0);
    // A drops, B rises same edge: direct handover
    add(0, 1, 0, 1, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1);
    // uncontested A held 10 cycles past MAX_HOLD
    for (int i = 0; i < 10; i++)
      add(1, 0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    // contested from IDLE with last=A: B wins
    add(1, 1, 1, 0, 0, 1, 1, 1, 0);
    add(1, 1, 1, 0, 0, 1, 1, 1, 0);

    drive4(0, 0, 0, 0);
    if1.req_a = 1'b0;
    if1.req_b = 1'b0;
    if1.a     = 1'b1;
    if1.b     = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset4", 5'b00000);
    check(outs4());
    expect_out("reset1", 5'b00001);
    check(outs1());
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive4(tbl[i].ra, tbl[i].rb, tbl[i].a, tbl[i].b);
      expect_out($sformatf("vec%0d", i),
                 {tbl[i].ga, tbl[i].gb, tbl[i].sel,
                  tbl[i].yv, tbl[i].y});
      @(posedge clk);
      #1;
      check(outs4());
    end

    // async reset while B holds the mux, between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 5'b00001);
    check(outs4());
    drive4(1, 1, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("rst_a_first", 5'b10011);
    @(posedge clk);
    #1;
    check(outs4());
    @(negedge clk);
    drive4(0, 0, 0, 0);

    // MAX_HOLD=1: alternate every cycle
    if1.req_a = 1'b1;
    if1.req_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if ((k % 2) == 0)
        expect_out($sformatf("mh1_%0d", k), 5'b10011);
      else
        expect_out($sformatf("mh1_%0d", k), 5'b01110);
      @(posedge clk);
      #1;
      check(outs1());
      n_vec++;
      if (if1.gnt_a && if1.gnt_b) begin
        n_bad++;
        $display("FAIL mh1_onehot%0d got 11 want not 11", k);
      end
    end

    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got %0d want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
